bus_master_port: RTL and testbench
==================================

# bus_master_port

Master-side serial bus port: the initiating end of the single-wire serial bus whose receiving end is the slave. It accepts a parallel request (slave ID, address, read/write, write data) from the local module, serialises the header and write data onto the bus, and for reads waits for the slave's start bit, deserialises the returned data and presents it in parallel. It sits between a master core and the shared bus wires (`data_bus_serial`, `bus_util`, `rd_wrt`, `slave_busy`).

## Interface
- `DATA_WIDTH`, 8, data word width
- `ADDRESS_WIDTH`, 15, slave-internal address width
- `SLAVE_ID_WIDTH`, 2, slave ID width
- `TIMEOUT_CYCLES`, 1024, maximum wait for slave response or busy release
- `clk`  in  1  bus clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  1  start transaction; sampled only when `ready`=1
- `req_rd_wrt`  in  1  1 = read, 0 = write
- `req_slave_id`  in  SLAVE_ID_WIDTH  target slave
- `req_addr`  in  ADDRESS_WIDTH  target address
- `req_wdata`  in  DATA_WIDTH  write data
- `ready`  out  1  idle, can accept `req`
- `done`  out  1  one-cycle pulse at transaction end
- `err`  out  1  valid with `done`; 1 = timeout
- `rdata`  out  DATA_WIDTH  read data, valid from `done` until next read completes
- `bus_util`  out  1  header phase in progress
- `rd_wrt`  out  1  transaction direction on bus
- `data_bus_out`  out  1  serial drive value
- `data_bus_oe`  out  1  1 = master drives serial line (top level builds tri-state)
- `data_bus_in`  in  1  serial line sampled value
- `slave_busy`  in  1  wired-OR busy from slaves (pulled high by a busy slave)

## Operation
- Line idles high; `data_bus_oe`=1, `data_bus_out`=1 when idle.
- Frame, one bit per clock, MSB first: start bit 0, ID bits, address bits; write adds DATA_WIDTH data bits.
- `req`/`req_*` captured into internal registers in IDLE; inputs may change afterwards.
- States: IDLE → START → ID → ADDR → (write) WDATA → WAIT_BUSY → DONE; (read) RD_WAIT → RDATA → DONE; DONE → IDLE.
- `bus_util`=1 in START, ID, ADDR; 0 otherwise. `rd_wrt` = captured direction from START through DONE, 0 in IDLE.
- WAIT_BUSY: line driven high; leave when `slave_busy`=0 (first check in the cycle after the last data bit).
- RD_WAIT: `data_bus_oe`=0; wait for `data_bus_in`=0 (slave start bit), then RDATA samples DATA_WIDTH bits into a shift register.
- Timeout counter runs in WAIT_BUSY and RD_WAIT, cleared on entry; reaching TIMEOUT_CYCLES → DONE with `err`=1; `rdata` unchanged on error.
- Reset values: `ready`=1, `done`=0, `err`=0, `rdata`=0, `bus_util`=0, `rd_wrt`=0, `data_bus_out`=1, `data_bus_oe`=1, state IDLE.

## Timing
- `req` at edge N → START (line 0, `bus_util`=1) at N+1; `ready`=0 from N+1.
- Header occupies 1+SLAVE_ID_WIDTH+ADDRESS_WIDTH cycles (18 by default); first ID bit at N+2, last address bit at N+18.
- Write: data bits N+19..N+26; WAIT_BUSY from N+27; `done` earliest at N+28; `ready`=1 the cycle after `done`.
- Read: line released at N+19; start bit seen at cycle S → data bits S+1..S+DATA_WIDTH; `done` and `rdata` valid at S+DATA_WIDTH+1.
- `req` while `ready`=0: ignored, no queueing.
- `rst` has priority over `req` and over any state; mid-frame reset returns line high/driven and `bus_util`=0 at the next edge.
- Counter width `$clog2(TIMEOUT_CYCLES+1)`; bit counter width `$clog2` of the largest field, no wrap within a field.

## Structure
- Shared `bus_pkg`: width defaults, state enum, idle-line level, start-bit value, slave ID constants.
- One sub-module: `bus_timeout_ctr` (clear, enable, expire flag), reused by slave and arbiter.
- Single shift register reused for transmit (header/data) and receive.

## Test plan
- Write ID=2'b11, addr=15'h1234, data=8'hA5, `slave_busy` low → serial 0,1,1,(0x1234 MSB first),(0xA5 MSB first); `done` at N+28, `err`=0.
- Write with `slave_busy` held high 40 cycles after last bit → `done` exactly one cycle after `slave_busy` falls.
- Read addr=15'h0003, model slave sends start bit 50 cycles after release then 8'h3C → `rdata`=8'h3C, `done` pulse, `err`=0, `data_bus_oe`=0 throughout RD_WAIT/RDATA.
- Read, slave never responds, TIMEOUT_CYCLES=16 → `done` with `err`=1 16 cycles after release, `rdata` keeps previous value.
- Second `req` asserted during header → ignored; `ready` returns 1 only after first `done`.
- `rst` asserted at ADDR bit 5 → next edge: `bus_util`=0, line high, `ready`=1, no `done`.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the single-wire serial bus: default widths, line
// levels, slave IDs and the master port state encoding.
package bus_pkg;

    localparam int BUS_DATA_WIDTH     = 8;
    localparam int BUS_ADDRESS_WIDTH  = 15;
    localparam int BUS_SLAVE_ID_WIDTH = 2;
    localparam int BUS_TIMEOUT_CYCLES = 1024;

    // The line rests high; a low bit marks the start of every frame or reply.
    localparam logic BUS_IDLE_LEVEL = 1'b1;
    localparam logic BUS_START_BIT  = 1'b0;

    localparam logic [BUS_SLAVE_ID_WIDTH-1:0] SLAVE_ID_0 = 2'd0;
    localparam logic [BUS_SLAVE_ID_WIDTH-1:0] SLAVE_ID_1 = 2'd1;
    localparam logic [BUS_SLAVE_ID_WIDTH-1:0] SLAVE_ID_2 = 2'd2;
    localparam logic [BUS_SLAVE_ID_WIDTH-1:0] SLAVE_ID_3 = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_ID        = 4'd2,
        ST_ADDR      = 4'd3,
        ST_WDATA     = 4'd4,
        ST_WAIT_BUSY = 4'd5,
        ST_RD_WAIT   = 4'd6,
        ST_RDATA     = 4'd7,
        ST_DONE      = 4'd8
    } bus_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_master_port_if.sv
// Request/response handshake plus serial bus wires seen by the master port.
interface bus_master_port_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 15,
    parameter int SLAVE_ID_WIDTH = 2
);
    logic                      req;
    logic                      req_rd_wrt;
    logic [SLAVE_ID_WIDTH-1:0] req_slave_id;
    logic [ADDRESS_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      ready;
    logic                      done;
    logic                      err;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      bus_util;
    logic                      rd_wrt;
    logic                      data_bus_out;
    logic                      data_bus_oe;
    logic                      data_bus_in;
    logic                      slave_busy;

    modport master (
        input  req, req_rd_wrt, req_slave_id, req_addr, req_wdata,
        input  data_bus_in, slave_busy,
        output ready, done, err, rdata,
        output bus_util, rd_wrt, data_bus_out, data_bus_oe
    );

    modport slave (
        output req, req_rd_wrt, req_slave_id, req_addr, req_wdata,
        output data_bus_in, slave_busy,
        input  ready, done, err, rdata,
        input  bus_util, rd_wrt, data_bus_out, data_bus_oe
    );

endinterface

// File: rtl/bus_timeout_ctr.sv
// Saturating wait counter: cleared while idle, counts enabled cycles and flags
// the cycle in which the wait reaches TIMEOUT_CYCLES.
module bus_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The flag is raised during the last permitted wait cycle so the owner leaves on that edge.
    assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next count: clear wins, then count while enabled, holding once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_master_port.sv
// Master end of the single-wire serial bus: serialises a captured request,
// waits for busy release (write) or the slave reply (read), reports done/err.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH     = BUS_DATA_WIDTH,
    parameter int ADDRESS_WIDTH  = BUS_ADDRESS_WIDTH,
    parameter int SLAVE_ID_WIDTH = BUS_SLAVE_ID_WIDTH,
    parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    bus_master_port_if.master  bus
);
    localparam int HDR_W     = SLAVE_ID_WIDTH + ADDRESS_WIDTH;
    localparam int SHIFT_W   = max_int(HDR_W, DATA_WIDTH);
    localparam int MAX_FIELD = max_int(max_int(SLAVE_ID_WIDTH, ADDRESS_WIDTH), DATA_WIDTH);
    localparam int BIT_CNT_W = (MAX_FIELD > 1) ? $clog2(MAX_FIELD) : 1;

    bus_state_e             state_q;
    logic [SHIFT_W-1:0]     shift_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic                   ready_q;
    logic                   done_q;
    logic                   err_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   bus_util_q;
    logic                   rd_wrt_q;
    logic                   out_q;
    logic                   oe_q;

    logic                   waiting_s;
    logic                   expired_s;
    logic [SHIFT_W-1:0]     hdr_al_s;
    logic [SHIFT_W-1:0]     wdata_al_s;

    // One shift register serves every field: words are left-aligned so the MSB always leaves first.
    assign hdr_al_s   = SHIFT_W'({bus.req_slave_id, bus.req_addr}) << (SHIFT_W - HDR_W);
    assign wdata_al_s = SHIFT_W'(wdata_q) << (SHIFT_W - DATA_WIDTH);
    assign waiting_s  = (state_q == ST_WAIT_BUSY) || (state_q == ST_RD_WAIT);

    bus_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!waiting_s),
        .en_i      (waiting_s),
        .expired_o (expired_s)
    );

    // Frame sequencer; every bus-facing output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            wdata_q    <= '0;
            bit_cnt_q  <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            bus_util_q <= 1'b0;
            rd_wrt_q   <= 1'b0;
            out_q      <= BUS_IDLE_LEVEL;
            oe_q       <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req) begin
                        state_q    <= ST_START;
                        shift_q    <= hdr_al_s;
                        wdata_q    <= bus.req_wdata;
                        rd_wrt_q   <= bus.req_rd_wrt;
                        ready_q    <= 1'b0;
                        bus_util_q <= 1'b1;
                        out_q      <= BUS_START_BIT;
                        oe_q       <= 1'b1;
                    end else begin
                        ready_q    <= 1'b1;
                    end
                end
                ST_START: begin
                    state_q   <= ST_ID;
                    bit_cnt_q <= BIT_CNT_W'(SLAVE_ID_WIDTH - 1);
                    out_q     <= shift_q[SHIFT_W-1];
                    shift_q   <= {shift_q[SHIFT_W-2:0], 1'b0};
                end
                ST_ID: begin
                    out_q   <= shift_q[SHIFT_W-1];
                    shift_q <= {shift_q[SHIFT_W-2:0], 1'b0};
                    if (bit_cnt_q == '0) begin
                        state_q   <= ST_ADDR;
                        bit_cnt_q <= BIT_CNT_W'(ADDRESS_WIDTH - 1);
                    end else begin
                        bit_cnt_q <= bit_cnt_q - BIT_CNT_W'(1);
                    end
                end
                ST_ADDR: begin
                    if (bit_cnt_q == '0) begin
                        bus_util_q <= 1'b0;
                        if (rd_wrt_q) begin
                            state_q <= ST_RD_WAIT;
                            oe_q    <= 1'b0;
                            out_q   <= BUS_IDLE_LEVEL;
                        end else begin
                            state_q   <= ST_WDATA;
                            out_q     <= wdata_al_s[SHIFT_W-1];
                            shift_q   <= {wdata_al_s[SHIFT_W-2:0], 1'b0};
                            bit_cnt_q <= BIT_CNT_W'(DATA_WIDTH - 1);
                        end
                    end else begin
                        out_q     <= shift_q[SHIFT_W-1];
                        shift_q   <= {shift_q[SHIFT_W-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q - BIT_CNT_W'(1);
                    end
                end
                ST_WDATA: begin
                    if (bit_cnt_q == '0) begin
                        state_q <= ST_WAIT_BUSY;
                        out_q   <= BUS_IDLE_LEVEL;
                    end else begin
                        out_q     <= shift_q[SHIFT_W-1];
                        shift_q   <= {shift_q[SHIFT_W-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q - BIT_CNT_W'(1);
                    end
                end
                ST_WAIT_BUSY: begin
                    // Busy release takes precedence if it coincides with expiry.
                    if (!bus.slave_busy) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end else if (expired_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT_BUSY;
                    end
                end
                ST_RD_WAIT: begin
                    if (bus.data_bus_in == BUS_START_BIT) begin
                        state_q   <= ST_RDATA;
                        bit_cnt_q <= BIT_CNT_W'(DATA_WIDTH - 1);
                    end else if (expired_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        oe_q    <= 1'b1;
                        out_q   <= BUS_IDLE_LEVEL;
                    end else begin
                        state_q <= ST_RD_WAIT;
                    end
                end
                ST_RDATA: begin
                    shift_q <= {shift_q[SHIFT_W-2:0], bus.data_bus_in};
                    if (bit_cnt_q == '0) begin
                        state_q <= ST_DONE;
                        rdata_q <= {shift_q[DATA_WIDTH-2:0], bus.data_bus_in};
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        oe_q    <= 1'b1;
                        out_q   <= BUS_IDLE_LEVEL;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - BIT_CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                    ready_q  <= 1'b1;
                    rd_wrt_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    ready_q    <= 1'b1;
                    done_q     <= 1'b0;
                    err_q      <= 1'b0;
                    bus_util_q <= 1'b0;
                    rd_wrt_q   <= 1'b0;
                    out_q      <= BUS_IDLE_LEVEL;
                    oe_q       <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready        = ready_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.rdata        = rdata_q;
    assign bus.bus_util     = bus_util_q;
    assign bus.rd_wrt       = rd_wrt_q;
    assign bus.data_bus_out = out_q;
    assign bus.data_bus_oe  = oe_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: one default instance and one with a
// 16-cycle timeout, checked at the falling edge against hand-computed values.
module tb_bus_master_port;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_master_port_if bif ();
    bus_master_port_if bif_to ();

    bus_master_port dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    bus_master_port #(
        .TIMEOUT_CYCLES (16)
    ) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (bif_to.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [25:0] frame;
    logic [7:0]  rdval;
    logic        ok;

    initial begin
        rst = 1'b1;
        bif.req = 1'b0;    bif.req_rd_wrt = 1'b0;    bif.req_slave_id = SLAVE_ID_0;
        bif.req_addr = 15'h0000; bif.req_wdata = 8'h00;
        bif.data_bus_in = 1'b1; bif.slave_busy = 1'b0;
        bif_to.req = 1'b0; bif_to.req_rd_wrt = 1'b0; bif_to.req_slave_id = SLAVE_ID_0;
        bif_to.req_addr = 15'h0000; bif_to.req_wdata = 8'h00;
        bif_to.data_bus_in = 1'b1; bif_to.slave_busy = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);

        // Reset values: {ready,done,err,bus_util,rd_wrt,out,oe}
        chk("rst_outs", {bif.ready, bif.done, bif.err, bif.bus_util, bif.rd_wrt,
                         bif.data_bus_out, bif.data_bus_oe}, 7'b1000011);
        chk("rst_rdata", bif.rdata, 8'h00);
        chk("rst_outs_to", {bif_to.ready, bif_to.done, bif_to.err, bif_to.bus_util,
                            bif_to.rd_wrt, bif_to.data_bus_out, bif_to.data_bus_oe}, 7'b1000011);
        chk("rst_rdata_to", bif_to.rdata, 8'h00);

        // Write ID=3 addr=0x1234 data=0xA5; a second req during the header must be ignored
        bif.req = 1'b1; bif.req_rd_wrt = 1'b0; bif.req_slave_id = SLAVE_ID_3;
        bif.req_addr = 15'h1234; bif.req_wdata = 8'hA5;
        cyc(1);
        bif.req = 1'b0; bif.req_slave_id = SLAVE_ID_0;
        bif.req_addr = 15'h7FFF; bif.req_wdata = 8'h00;
        chk("wr_start", {bif.ready, bif.bus_util, bif.data_bus_out, bif.data_bus_oe, bif.rd_wrt}, 5'b01010);
        ok = 1'b1;
        for (int i = 0; i < 26; i++) begin
            frame = {frame[24:0], bif.data_bus_out};
            if (bif.data_bus_oe !== 1'b1 || bif.bus_util !== (i < 18) || bif.ready !== 1'b0) ok = 1'b0;
            if (i == 3) bif.req = 1'b1;
            if (i == 9) bif.req = 1'b0;
            cyc(1);
        end
        chk("wr_frame", frame, {1'b0, 2'b11, 15'h1234, 8'hA5});
        chk("wr_frame_ctl", ok, 1'b1);
        chk("wr_wait", {bif.done, bif.bus_util, bif.data_bus_out, bif.data_bus_oe, bif.ready}, 5'b00110);
        cyc(1);
        chk("wr_done", {bif.done, bif.err, bif.ready}, 3'b100);
        cyc(1);
        chk("wr_ready", {bif.done, bif.ready, bif.bus_util}, 3'b010);
        cyc(1);
        chk("wr_no_queue", {bif.ready, bif.bus_util, bif.data_bus_out}, 3'b101);

        // Write with slave_busy held 40 cycles past the last data bit
        bif.req = 1'b1; bif.req_rd_wrt = 1'b0; bif.req_slave_id = SLAVE_ID_1;
        bif.req_addr = 15'h0001; bif.req_wdata = 8'h0F; bif.slave_busy = 1'b1;
        cyc(1);
        bif.req = 1'b0;
        cyc(26);
        ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (bif.done !== 1'b0) ok = 1'b0;
            cyc(1);
        end
        bif.slave_busy = 1'b0;
        chk("busy_hold", {ok, bif.done}, 2'b10);
        cyc(1);
        chk("busy_done", {bif.done, bif.err}, 2'b10);
        cyc(1);

        // Read addr=3; slave start bit 50 cycles after release, then 0x3C
        bif.req = 1'b1; bif.req_rd_wrt = 1'b1; bif.req_slave_id = SLAVE_ID_2;
        bif.req_addr = 15'h0003;
        cyc(1);
        bif.req = 1'b0;
        cyc(18);
        chk("rd_release", {bif.data_bus_oe, bif.bus_util, bif.rd_wrt, bif.done}, 4'b0010);
        ok = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (bif.data_bus_oe !== 1'b0 || bif.done !== 1'b0) ok = 1'b0;
            cyc(1);
        end
        rdval = 8'h3C;
        bif.data_bus_in = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            if (bif.data_bus_oe !== 1'b0 || bif.done !== 1'b0) ok = 1'b0;
            cyc(1);
            bif.data_bus_in = rdval[b];
        end
        cyc(1);
        bif.data_bus_in = 1'b1;
        chk("rd_oe_low", ok, 1'b1);
        chk("rd_done", {bif.done, bif.err, bif.data_bus_oe}, 3'b101);
        chk("rd_data", bif.rdata, 8'h3C);
        cyc(1);
        chk("rd_hold", {bif.done, bif.rdata}, {1'b0, 8'h3C});

        // Timeout instance: a good read of 0x5A, then a read nobody answers
        bif_to.req = 1'b1; bif_to.req_rd_wrt = 1'b1; bif_to.req_slave_id = SLAVE_ID_0;
        bif_to.req_addr = 15'h0010;
        cyc(1);
        bif_to.req = 1'b0;
        cyc(18);
        rdval = 8'h5A;
        bif_to.data_bus_in = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            cyc(1);
            bif_to.data_bus_in = rdval[b];
        end
        cyc(1);
        bif_to.data_bus_in = 1'b1;
        chk("to_first_read", {bif_to.done, bif_to.err, bif_to.rdata}, {2'b10, 8'h5A});
        cyc(1);
        bif_to.req = 1'b1; bif_to.req_addr = 15'h0020; bif_to.req_slave_id = SLAVE_ID_2;
        cyc(1);
        bif_to.req = 1'b0;
        cyc(18);
        chk("to_release", {bif_to.data_bus_oe, bif_to.rd_wrt}, 2'b01);
        ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (bif_to.done !== 1'b0) ok = 1'b0;
            cyc(1);
        end
        chk("to_no_early_done", ok, 1'b1);
        chk("to_done_err", {bif_to.done, bif_to.err, bif_to.data_bus_oe, bif_to.data_bus_out}, 4'b1111);
        chk("to_rdata_kept", bif_to.rdata, 8'h5A);

        // Reset during address bit 5 of a write
        cyc(2);
        bif.req = 1'b1; bif.req_rd_wrt = 1'b0; bif.req_slave_id = SLAVE_ID_3;
        bif.req_addr = 15'h7FFF; bif.req_wdata = 8'hFF;
        cyc(1);
        bif.req = 1'b0;
        cyc(8);
        chk("rst_pre", {bif.bus_util, bif.ready, bif.data_bus_out}, 3'b101);
        rst = 1'b1;
        cyc(1);
        chk("rst_mid", {bif.bus_util, bif.data_bus_out, bif.data_bus_oe, bif.ready,
                        bif.done, bif.rd_wrt}, 6'b011100);
        rst = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (bif.done !== 1'b0 || bif.bus_util !== 1'b0 || bif.ready !== 1'b1) ok = 1'b0;
            cyc(1);
        end
        chk("rst_no_done", ok, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
